alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle shift-and-add multiply sequencer that owns the execute-stage 16-bit ALU while a multiply is in flight. It is placed between the execute-stage operand/control signals and the shared ALU instance. When idle it passes the pipeline's ALU controls straight through. On `mul_start` it takes the ALU, runs up to 16 accumulate steps, and returns the low 16 product bits with a one-cycle `mul_done` pulse.

## Interface
- `WIDTH`, 16, operand/product width
- `OPER_W`, 4, ALU operation-code width
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `mul_start`  in  1  start request; sampled only in IDLE
- `mul_a`, `mul_b`  in  WIDTH  multiplicand, multiplier
- `mul_busy`  out  1  high in RUN and DONE; pipeline stalls on it
- `mul_done`  out  1  one-cycle pulse, result valid
- `mul_result`  out  WIDTH  low WIDTH bits of `mul_a*mul_b`; held until next start
- `mul_ovf`  out  1  unsigned product exceeded WIDTH bits; held with result
- `ex_InA`, `ex_InB`  in  WIDTH  pipeline ALU operands
- `ex_Oper`  in  OPER_W  pipeline operation code
- `ex_Cin`, `ex_invA`, `ex_invB`, `ex_sign`  in  1 each  pipeline ALU controls
- `alu_InA`, `alu_InB`  out  WIDTH  to ALU
- `alu_Oper`  out  OPER_W  to ALU
- `alu_Cin`, `alu_invA`, `alu_invB`, `alu_sign`  out  1 each  to ALU
- `alu_Out`  in  WIDTH  ALU result
- `alu_OF`  in  1  ALU overflow; carry-out when `alu_sign`=0

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - ALU outputs equal the `ex_*` inputs, combinationally.
  - On `mul_start`: `mcand<=mul_a`, `mplier<=mul_b`, `acc<=0`, `cnt<=0`, `lost<=0`, `ovf<=0`; go to RUN.
- **RUN**
  - ALU is driven by the controller: `InA=acc`, `InB=mcand`, `Oper=OPER_ADD` (4'b0100), `Cin=0`, `invA=invB=sign=0`. The `ex_*` inputs are ignored.
  - If `mplier==0` or `cnt==WIDTH`: go to DONE. No state update.
  - Otherwise, if `mplier[0]`:
    - `acc<=alu_Out`
    - `ovf<=ovf|alu_OF|lost`
  - Every step:
    - `lost<=lost|mcand[WIDTH-1]`
    - `mcand<<=1`, `mplier>>=1`, `cnt++`
- **DONE**
  - `mul_done=1`; `mul_result<=acc`; `mul_ovf<=ovf`; go to IDLE.
  - ALU is still controller-driven with RUN values. The ALU result is unused.
- `mul_start` is ignored in RUN and DONE. No queueing.
- A start may be accepted in the IDLE cycle directly after DONE.
- Reset mid-operation: all state is cleared immediately, the block returns to IDLE pass-through, and no `mul_done` is issued.

## Timing
- Reset values:
  - `mul_busy=0`, `mul_done=0`, `mul_result=0`, `mul_ovf=0`.
  - ALU outputs follow `ex_*`.
- If start is sampled at edge N, RUN begins in cycle N+1.
- k = position of the highest set bit of `mul_b` plus 1 (0 if `mul_b`=0).
- `mul_done` is high in cycle N+k+2, and `mul_result`/`mul_ovf` update at the end of that cycle.
- Latency: minimum 2 cycles (`mul_b`=0); maximum 18 cycles (bit 15 set).
- `mul_busy` is high from N+1 through N+k+2 inclusive.
- `mul_done` and `mul_busy` decode directly from the state register. No combinational path exists from `mul_start`.
- The controller-to-ALU-to-`acc` path is single-cycle, and the ALU is purely combinational.

## Structure
- Package `alu_pkg`:
  - `OPER_ADD` and the other ALU `Oper` codes
  - `mul_state_t` enum (IDLE/RUN/DONE)
  - `WIDTH` default
- No sub-module. The ALU instance stays in the execute stage; this block only muxes its inputs.
- Counter width is `$clog2(WIDTH)+1`.

## Test plan
- `mul_a`=3, `mul_b`=5 → done at N+5, result 0x000F, ovf 0. During RUN, `alu_Oper`=4'b0100.
- `mul_a`=0x1234, `mul_b`=0 → done at N+2, result 0x0000, ovf 0.
- 0xFFFF×0xFFFF → done at N+18, result 0x0001, ovf 1.
- 0x0100×0x0100 → result 0x0000, ovf 1 (overflow via the `lost` path, no ALU OF).
- While IDLE, random `ex_*` → `alu_*` match exactly. While busy, `alu_*` ignore `ex_*`, and a second `mul_start` has no effect.
- Deassert `rst_n` in cycle N+3 of 0xFFFF×0xFFFF → `mul_busy`=0 immediately, no `mul_done`, pass-through restored. Then 2×7 yields 0x000E.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared execute-stage ALU definitions: operation codes, default widths and
// the multiply sequencer state type.
package alu_pkg;

    localparam int ALU_WIDTH  = 16;
    localparam int ALU_OPER_W = 4;

    localparam logic [ALU_OPER_W-1:0] OPER_ROL = 4'b0000;
    localparam logic [ALU_OPER_W-1:0] OPER_SLL = 4'b0001;
    localparam logic [ALU_OPER_W-1:0] OPER_ROR = 4'b0010;
    localparam logic [ALU_OPER_W-1:0] OPER_SRL = 4'b0011;
    localparam logic [ALU_OPER_W-1:0] OPER_ADD = 4'b0100;
    localparam logic [ALU_OPER_W-1:0] OPER_OR  = 4'b0101;
    localparam logic [ALU_OPER_W-1:0] OPER_XOR = 4'b0110;
    localparam logic [ALU_OPER_W-1:0] OPER_AND = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer that borrows the execute-stage ALU while a
// multiply is in flight and passes pipeline ALU controls through otherwise.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int OPER_W = ALU_OPER_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mul_start,
    input  logic [WIDTH-1:0]  mul_a,
    input  logic [WIDTH-1:0]  mul_b,
    output logic              mul_busy,
    output logic              mul_done,
    output logic [WIDTH-1:0]  mul_result,
    output logic              mul_ovf,
    input  logic [WIDTH-1:0]  ex_InA,
    input  logic [WIDTH-1:0]  ex_InB,
    input  logic [OPER_W-1:0] ex_Oper,
    input  logic              ex_Cin,
    input  logic              ex_invA,
    input  logic              ex_invB,
    input  logic              ex_sign,
    output logic [WIDTH-1:0]  alu_InA,
    output logic [WIDTH-1:0]  alu_InB,
    output logic [OPER_W-1:0] alu_Oper,
    output logic              alu_Cin,
    output logic              alu_invA,
    output logic              alu_invB,
    output logic              alu_sign,
    input  logic [WIDTH-1:0]  alu_Out,
    input  logic              alu_OF
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mul_state_t       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             lost;
    logic             ovf;

    // NOTE: every register here, datapath included, is reset asynchronously and
    // updated with <= so all branches see the pre-edge values of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            lost       <= 1'b0;
            ovf        <= 1'b0;
            mul_result <= '0;
            mul_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        mcand  <= mul_a;
                        mplier <= mul_b;
                        acc    <= '0;
                        cnt    <= '0;
                        lost   <= 1'b0;
                        ovf    <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (mplier == '0 || cnt == CNT_W'(WIDTH)) begin
                        state <= DONE;
                    end else begin
                        // A bit shifted out of mcand only matters if a later add uses it.
                        if (mplier[0]) begin
                            acc <= alu_Out;
                            ovf <= ovf | alu_OF | lost;
                        end
                        lost   <= lost | mcand[WIDTH-1];
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    mul_result <= acc;
                    mul_ovf    <= ovf;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mul_busy = (state != IDLE);
    assign mul_done = (state == DONE);

    // NOTE: every output gets a default before the override so no latch is inferred.
    always_comb begin
        alu_InA  = ex_InA;
        alu_InB  = ex_InB;
        alu_Oper = ex_Oper;
        alu_Cin  = ex_Cin;
        alu_invA = ex_invA;
        alu_invB = ex_invB;
        alu_sign = ex_sign;
        if (state != IDLE) begin
            alu_InA  = acc;
            alu_InB  = mcand;
            alu_Oper = OPER_W'(OPER_ADD);
            alu_Cin  = 1'b0;
            alu_invA = 1'b0;
            alu_invB = 1'b0;
            alu_sign = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: random and corner multiplies against a
// full-width arithmetic reference, plus ALU pass-through and mid-run reset.
module tb_alu_mul_seq;

    localparam logic [3:0] ADD_CODE = 4'b0100;

    logic        clk;
    logic        rst_n;
    logic        mul_start;
    logic [15:0] mul_a, mul_b;
    logic        mul_busy, mul_done, mul_ovf;
    logic [15:0] mul_result;
    logic [15:0] ex_InA, ex_InB;
    logic [3:0]  ex_Oper;
    logic        ex_Cin, ex_invA, ex_invB, ex_sign;
    logic [15:0] alu_InA, alu_InB, alu_Out;
    logic [3:0]  alu_Oper;
    logic        alu_Cin, alu_invA, alu_invB, alu_sign, alu_OF;

    int errors = 0;
    int checks = 0;

    alu_mul_seq dut (
        .clk(clk), .rst_n(rst_n),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_busy(mul_busy), .mul_done(mul_done),
        .mul_result(mul_result), .mul_ovf(mul_ovf),
        .ex_InA(ex_InA), .ex_InB(ex_InB), .ex_Oper(ex_Oper),
        .ex_Cin(ex_Cin), .ex_invA(ex_invA), .ex_invB(ex_invB), .ex_sign(ex_sign),
        .alu_InA(alu_InA), .alu_InB(alu_InB), .alu_Oper(alu_Oper),
        .alu_Cin(alu_Cin), .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
        .alu_Out(alu_Out), .alu_OF(alu_OF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU stand-in: add for the ADD code, xor for anything else.
    logic [15:0] opa, opb;
    logic [16:0] sum;
    always_comb begin
        opa = alu_invA ? ~alu_InA : alu_InA;
        opb = alu_invB ? ~alu_InB : alu_InB;
        sum = {1'b0, opa} + {1'b0, opb} + {16'd0, alu_Cin};
        if (alu_Oper == ADD_CODE) begin
            alu_Out = sum[15:0];
            alu_OF  = alu_sign ? ((opa[15] == opb[15]) && (sum[15] != opa[15])) : sum[16];
        end else begin
            alu_Out = opa ^ opb;
            alu_OF  = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rand_ex();
        ex_InA  = 16'($urandom);
        ex_InB  = 16'($urandom);
        ex_Oper = 4'($urandom);
        ex_Cin  = 1'($urandom);
        ex_invA = 1'($urandom);
        ex_invB = 1'($urandom);
        ex_sign = 1'($urandom);
    endtask

    task automatic check_pass(input string tag);
        rand_ex();
        #1;
        check(tag, {26'd0, alu_InA, alu_InB, alu_Oper, alu_Cin, alu_invA, alu_invB, alu_sign},
                   {26'd0, ex_InA, ex_InB, ex_Oper, ex_Cin, ex_invA, ex_invB, ex_sign});
    endtask

    // Called #1 after a posedge while idle; returns #1 after the posedge that
    // follows the done cycle. poke drives spurious starts while busy.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input bit poke);
        logic [31:0] prod;
        int          k;
        bit          seen;
        prod = {16'd0, a} * {16'd0, b};
        k = 0;
        for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
        mul_a = a;
        mul_b = b;
        mul_start = 1'b1;
        @(posedge clk); #1;
        mul_start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (mul_done) begin
                seen = 1'b1;
                check($sformatf("latency %h*%h", a, b), 64'(c), 64'(k + 2));
                check("busy_in_done", 64'(mul_busy), 64'd1);
            end else begin
                check("busy_in_run", 64'(mul_busy), 64'd1);
                rand_ex();
                if (poke) begin
                    mul_start = 1'($urandom);
                    mul_a = 16'($urandom);
                    mul_b = 16'($urandom);
                end
                #1;
                check("run_alu_ctrl", {56'd0, alu_Oper, alu_Cin, alu_invA, alu_invB, alu_sign},
                                      {56'd0, ADD_CODE, 4'b0000});
                @(posedge clk); #1;
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        mul_start = 1'b0;
        @(posedge clk); #1;
        check($sformatf("result %h*%h", a, b), 64'(mul_result), 64'(prod[15:0]));
        check($sformatf("ovf %h*%h", a, b), 64'(mul_ovf), 64'(prod[31:16] != 16'd0));
        check("idle_after_done", {62'd0, mul_busy, mul_done}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        mul_start = 1'b0;
        mul_a = '0;
        mul_b = '0;
        rand_ex();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_done", {62'd0, mul_busy, mul_done}, 64'd0);
        check("rst_result_ovf", {47'd0, mul_result, mul_ovf}, 64'd0);
        check_pass("rst_pass");
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            check_pass("idle_pass");
            @(posedge clk); #1;
        end

        run_mul(16'd3, 16'd5, 1'b0);
        run_mul(16'h1234, 16'h0000, 1'b0);
        run_mul(16'hFFFF, 16'hFFFF, 1'b1);
        run_mul(16'h0100, 16'h0100, 1'b0);
        run_mul(16'h8000, 16'h0001, 1'b0);
        run_mul(16'h8000, 16'h0002, 1'b1);
        run_mul(16'h0001, 16'h8000, 1'b0);
        check_pass("idle_pass_after_run");
        for (int i = 0; i < 20; i++) begin
            logic [15:0] b;
            b = 16'($urandom) >> $urandom_range(0, 16);
            run_mul(16'($urandom) >> $urandom_range(0, 12), b, 1'($urandom));
        end

        // Reset in cycle N+3 of a long multiply.
        begin
            bit seen_done;
            mul_a = 16'hFFFF;
            mul_b = 16'hFFFF;
            mul_start = 1'b1;
            @(posedge clk); #1;
            mul_start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("busy_before_rst", 64'(mul_busy), 64'd1);
            rst_n = 1'b0;
            #1;
            check("rst_mid_busy_done", {62'd0, mul_busy, mul_done}, 64'd0);
            check_pass("rst_mid_pass");
            @(posedge clk); #1;
            rst_n = 1'b1;
            seen_done = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (mul_done || mul_busy) seen_done = 1'b1;
            end
            check("no_done_after_rst", 64'(seen_done), 64'd0);
            check("result_cleared", 64'(mul_result), 64'd0);
            check_pass("pass_after_rst");
            run_mul(16'd2, 16'd7, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
